// File: rtl/fifo_write_arbiter.sv
// Purpose: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Latency: grant one cycle after a request is seen in IDLE; one word/cycle in a burst; one bubble between bursts.
// Backpressure: fifo_full stalls the owner (grant low, ownership kept); fifo_almost_full only blocks new bursts.
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic [NUM_REQ-1:0]              req_last,
   output logic [NUM_REQ-1:0]              grant,
   output logic [DATA_WIDTH-1:0]           fifo_wr_data,
   output logic                            fifo_wr_en,
   input  logic                            fifo_full,
   input  logic                            fifo_almost_full,
   output logic                            busy,
   output logic [$clog2(NUM_REQ)-1:0]      cur_owner
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [OW:0]   NREQ_W     = (OW + 1)'(NUM_REQ);
   localparam logic [CW-1:0] CNT_LAST   = CW'(MAX_BURST - 1);
   localparam logic [OW-1:0] OWNER_INIT = OW'(NUM_REQ - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [OW-1:0]          last_owner;
   logic [CW-1:0]          burst_cnt;

   logic [OW:0]            start_pos;
   logic [OW:0]            sel_sum;
   logic [2*NUM_REQ-1:0]   req_rot;
   logic [OW-1:0]          first_ofs;
   logic [OW-1:0]          sel_idx;
   logic                   sel_vld;

   logic                   own_req;
   logic                   own_last;
   logic [DATA_WIDTH-1:0]  own_data;

   logic                   xfer;
   logic                   release_burst;
   logic                   start_burst;

   // Round-robin pick: rotate requests so bit 0 is last_owner+1, take the
   // lowest set bit, then map the offset back to an absolute index.
   always_comb begin
      start_pos = {1'b0, last_owner} + (OW + 1)'(1);
      req_rot   = {req, req} >> start_pos;
      sel_vld   = |req;
      first_ofs = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_rot[j]) begin
            first_ofs = OW'(j);
         end
      end
      sel_sum = start_pos + {1'b0, first_ofs};
      if (sel_sum >= NREQ_W) begin
         sel_sum = sel_sum - NREQ_W;
      end
      sel_idx = sel_sum[OW-1:0];
   end

   // Select the current owner's request, last flag and data slice.
   always_comb begin
      own_req  = 1'b0;
      own_last = 1'b0;
      own_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cur_owner == OW'(i)) begin
            own_req  = req[i];
            own_last = req_last[i];
            own_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state and output decode; a burst releases on its last word,
   // on the MAX_BURST-th word, or when the owner drops its request.
   always_comb begin
      state_nxt     = state;
      grant         = '0;
      fifo_wr_en    = 1'b0;
      fifo_wr_data  = '0;
      busy          = 1'b0;
      xfer          = 1'b0;
      release_burst = 1'b0;
      start_burst   = 1'b0;
      case (state)
         IDLE: begin
            if (sel_vld && !fifo_almost_full) begin
               start_burst = 1'b1;
               state_nxt   = BURST;
            end
         end
         BURST: begin
            busy = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (cur_owner == OW'(i)) begin
                  grant[i] = !fifo_full;
               end
            end
            xfer          = own_req && !fifo_full;
            fifo_wr_en    = xfer;
            fifo_wr_data  = own_data;
            release_burst = !own_req || (xfer && (own_last || (burst_cnt == CNT_LAST)));
            if (release_burst) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Ownership, priority pointer and per-burst word counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_owner  <= '0;
         last_owner <= OWNER_INIT;
         burst_cnt  <= '0;
      end else begin
         if (start_burst) begin
            cur_owner <= sel_idx;
            burst_cnt <= '0;
         end else if (xfer) begin
            burst_cnt <= burst_cnt + CW'(1);
         end
         if (release_burst) begin
            last_owner <= cur_owner;
         end
      end
   end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin burst arbiter that shares one single-read FIFO's write port between NUM_REQ producers.
- It sits in front of the FIFO: it drives the FIFO's write data and write enable, and uses the FIFO's full and almost_full status for back-pressure.
- A granted producer keeps ownership until it ends its burst, reaches MAX_BURST words or drops its request.
- No word is ever written while the FIFO reports full.

Parameters:
- NUM_REQ, 4, number of producers (>=2).
- DATA_WIDTH, 32, word width; must match the FIFO.
- MAX_BURST, 16, maximum words per grant before forced release (>=1).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_REQ  per-producer request; a high bit means a word is valid on that producer's data slice.
- req_data  input  NUM_REQ*DATA_WIDTH  producer data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  marks the final word of a producer's burst.
- grant  output  NUM_REQ  one-hot or zero; a word from producer i transfers in any cycle where req[i] & grant[i].
- fifo_wr_data  output  DATA_WIDTH  to FIFO wr_data.
- fifo_wr_en  output  1  to FIFO wr_en.
- fifo_full  input  1  from FIFO full.
- fifo_almost_full  input  1  from FIFO almost_full.
- busy  output  1  high while in BURST.
- cur_owner  output  $clog2(NUM_REQ)  index of current or last owner.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, grant=0, fifo_wr_en=0, busy=0, burst_cnt=0.
  - cur_owner=0; last_owner=NUM_REQ-1, so producer 0 has first priority.
  - fifo_wr_data is don't-care while fifo_wr_en=0.
  - Reset mid-burst abandons the burst immediately; a partial burst already written stays in the FIFO.
- IDLE state:
  - grant=0, fifo_wr_en=0.
  - If |req and !fifo_almost_full: select the first requesting index scanning last_owner+1, last_owner+2, ... modulo NUM_REQ.
  - Register the selection into cur_owner, clear burst_cnt, move to BURST next cycle.
  - Otherwise stay in IDLE.
- BURST state:
  - busy=1.
  - grant[cur_owner] = !fifo_full (combinational from fifo_full and state); all other grant bits are 0.
  - xfer = req[cur_owner] & grant[cur_owner].
  - fifo_wr_en = xfer (combinational).
  - fifo_wr_data = req_data slice of cur_owner (combinational mux).
  - On xfer, burst_cnt increments (width $clog2(MAX_BURST+1)).
- Release (BURST -> IDLE next cycle, last_owner <= cur_owner) when any of:
  - xfer & req_last[cur_owner];
  - xfer with burst_cnt == MAX_BURST-1 (forced truncation; the producer is re-arbitrated later and its req_last stays pending);
  - req[cur_owner] == 0 (producer abandoned; no word is written that cycle).
- If the release conditions coincide, the result is the same single release.
- Back-pressure:
  - fifo_almost_full only blocks starting a new burst; an ongoing burst continues.
  - fifo_full stalls transfers (grant low) without releasing ownership or changing burst_cnt.
- Latency and throughput:
  - The request seen in IDLE produces grant one cycle later; the first word writes in that cycle if not full.
  - Throughput is one word per cycle within a burst.
  - There is one idle bubble cycle between consecutive bursts.
- Fairness: a continuously requesting producer waits at most (NUM_REQ-1) bursts of at most MAX_BURST words each, plus bubbles and full stalls.
- Contention: requests from non-owners during BURST are ignored until the next IDLE cycle.
- Outputs never carry X after reset.

Test Plan:
- Single burst: only req[0] set, 3 words with req_last on the 3rd, FIFO empty -> grant[0] one cycle after req; fifo_wr_en high exactly 3 cycles carrying D0,D1,D2; returns to IDLE, busy low, cur_owner=0.
- Round-robin: all 4 producers request continuously with 2-word bursts -> grant order 0,1,2,3,0; 8 writes per round; one bubble between bursts; no two grant bits high.
- Truncation: producer 2 holds req with no req_last for 20 words, others idle -> writes 16 words, releases, re-granted after one bubble, remaining 4 words written; cur_owner=2 both times.
- Almost-full in IDLE: fifo_almost_full=1 with req=4'b0011 -> grant stays 0 and fifo_wr_en=0 until almost_full drops; then grant[0].
- Full mid-burst: fifo_full asserted for 5 cycles after the 2nd of 4 words -> grant and fifo_wr_en low for those 5 cycles, ownership held, burst_cnt=2; words 3-4 complete afterward.
- Reset and abandon: rst_n low for 1 cycle during a burst -> next cycle grant=0, busy=0, cur_owner=0, producer 0 has priority. Separately, the owner drops req mid-burst -> release with no write in that cycle, and the next requester is granted after IDLE.
